fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the IF/ID pipeline register.
- Owns the program counter and drives the instruction-memory address.
- Presents instruction, PC and a branch-prediction bit to IF/ID each cycle.
- Contains a direct-mapped branch predictor (2-bit BHT + BTB), trained by execute-stage resolution, plus a redirect path for mispredictions, jumps and traps.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- BHT_ENTRIES, 16, number of predictor entries; power of two, minimum 2; IDX_W = log2(BHT_ENTRIES).

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- stall_i  in  1  hold PC (hazard unit); same signal drives IF/ID stall.
- redirect_i  in  1  force next PC to redirect_pc_i (mispredict/jump/trap).
- redirect_pc_i  in  32  redirect target; bits [1:0] ignored.
- update_en_i  in  1  resolved control-flow instruction in execute.
- update_pc_i  in  32  PC of resolved branch.
- update_taken_i  in  1  actual branch outcome.
- update_target_i  in  32  actual taken target; bits [1:0] ignored.
- imem_addr_o  out  32  instruction memory address (combinational read memory).
- imem_rdata_i  in  32  instruction word at imem_addr_o, same cycle.
- instruction_o  out  32  to IF/ID instruction_i.
- pc_o  out  32  to IF/ID pc_i.
- br_pred_o  out  1  to IF/ID br_pred_i; 1 = predicted taken.

Behaviour:
- Reset (async, reset_n low):
  - pc = {RESET_PC[31:2], 2'b00}.
  - All BTB valid bits = 0; all BHT counters = 2'b01 (weakly not-taken); targets and tags = 0.
- Outputs are combinational from the pc register and the predictor arrays:
  - imem_addr_o = pc_o = pc.
  - instruction_o = imem_rdata_i.
- Lookup:
  - idx = pc[IDX_W+1:2]; tag = pc[31:IDX_W+2].
  - hit = valid[idx] && tag_mem[idx] == tag.
  - br_pred_o = hit && bht[idx][1].
- Next-PC priority, evaluated each rising edge:
  1. redirect_i: pc <= {redirect_pc_i[31:2], 2'b00}. Wins even when stall_i = 1.
  2. stall_i: pc holds.
  3. br_pred_o: pc <= target_mem[idx].
  4. Otherwise: pc <= pc + 4, wrapping modulo 2^32 (32'hFFFF_FFFC -> 32'h0).
- Latency:
  - New PC is visible on imem_addr_o the cycle after the edge.
  - Redirect costs one cycle of fetch; flushing the wrong-path instruction is IF/ID's job, not this block's.
- Predictor update, on the rising edge when update_en_i = 1; stall_i and redirect_i do not block training. With u_idx and u_tag derived from update_pc_i:
  - Tag hit, taken: counter saturating +1 (max 2'b11); target_mem <= update_target_i with [1:0] = 0.
  - Tag hit, not taken: counter saturating -1 (min 2'b00); target unchanged.
  - Miss (invalid or tag mismatch), taken: allocate the entry. valid = 1, tag = u_tag, target written, counter = 2'b10. Overwrites any previous occupant.
  - Miss, not taken: no state change.
- Simultaneous update and lookup to the same index: the lookup uses pre-update array contents (arrays are registers, written at the edge; no bypass).
- Reset mid-operation clears the predictor and PC immediately, independent of clk.
- No other state; no handshakes beyond stall_i and redirect_i.

Test Plan:
- Reset with RESET_PC = 32'h0000_0100, no stimulus:
  - While reset_n is low, imem_addr_o = 32'h100 and br_pred_o = 0.
  - After release, addresses run 0x100, 0x104, 0x108 on consecutive cycles.
- Stall vs redirect:
  - stall_i = 1 for 3 cycles at pc = 0x108: pc holds 0x108 for all 3 cycles.
  - stall_i = 1 and redirect_i = 1 with redirect_pc_i = 32'h0000_0203: next pc = 0x200.
- Training:
  - update_en_i with update_pc_i = 0x40, taken, target 0x80: entry allocated with counter 2'b10.
  - When pc later reaches 0x40: br_pred_o = 1, and the next pc = 0x80.
  - Two not-taken updates at 0x40: counter goes 2'b10 -> 01 -> 00, br_pred_o = 0 at 0x40, next pc = 0x44.
- Saturation:
  - Five taken updates at 0x40: counter stays 2'b11.
  - One not-taken update: counter = 2'b10, still predicts taken.
- Aliasing with BHT_ENTRIES = 16:
  - Train 0x40 taken, then 0x80 not-taken (same idx): entry unchanged.
  - Train 0x80 taken with target 0xC0: 0x40 no longer hits, br_pred_o = 0 at 0x40.
- Same-cycle update/lookup and wrap:
  - pc = 0x40 (entry invalid) while a taken update for 0x40 lands: that cycle br_pred_o = 0 and the next pc = 0x44.
  - From pc = 32'hFFFF_FFFC with no prediction: next pc = 0x0.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Bundles the fetch stage's control, training, instruction-memory and IF/ID signals.
// The slave modport is the fetch unit's view; master is the surrounding pipeline.
interface fetch_unit_if;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        update_en_i;
  logic [31:0] update_pc_i;
  logic        update_taken_i;
  logic [31:0] update_target_i;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_rdata_i;
  logic [31:0] instruction_o;
  logic [31:0] pc_o;
  logic        br_pred_o;

  modport master (
    output stall_i, redirect_i, redirect_pc_i,
    output update_en_i, update_pc_i, update_taken_i, update_target_i,
    output imem_rdata_i,
    input  imem_addr_o, instruction_o, pc_o, br_pred_o
  );

  modport slave (
    input  stall_i, redirect_i, redirect_pc_i,
    input  update_en_i, update_pc_i, update_taken_i, update_target_i,
    input  imem_rdata_i,
    output imem_addr_o, instruction_o, pc_o, br_pred_o
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC and predicts taken branches with a
// direct-mapped 2-bit BHT plus BTB, trained by execute-stage resolution.
module fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          BHT_ENTRIES = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  fetch_unit_if.slave   bus
);
  localparam int IDX_W = $clog2(BHT_ENTRIES);
  localparam int TAG_W = 30 - IDX_W;

  logic [31:0]      r_pc;
  logic             r_valid  [BHT_ENTRIES];
  logic [1:0]       r_bht    [BHT_ENTRIES];
  logic [TAG_W-1:0] r_tag    [BHT_ENTRIES];
  logic [31:0]      r_target [BHT_ENTRIES];

  logic [IDX_W-1:0] w_idx;
  logic [TAG_W-1:0] w_tag;
  logic             w_hit;
  logic             w_pred;
  logic [31:0]      w_next_pc;
  logic [31:0]      w_redirect_pc;
  logic [31:0]      w_u_pc;
  logic [31:0]      w_u_target;
  logic [IDX_W-1:0] w_u_idx;
  logic [TAG_W-1:0] w_u_tag;
  logic             w_u_hit;

  assign bus.imem_addr_o   = r_pc;
  assign bus.pc_o          = r_pc;
  assign bus.instruction_o = bus.imem_rdata_i;
  assign bus.br_pred_o     = w_pred;

  // Lookup and training decode; addresses are word-aligned by masking the low bits.
  always_comb begin
    w_redirect_pc = bus.redirect_pc_i & 32'hFFFF_FFFC;
    w_u_pc        = bus.update_pc_i & 32'hFFFF_FFFC;
    w_u_target    = bus.update_target_i & 32'hFFFF_FFFC;
    w_idx         = r_pc[IDX_W+1:2];
    w_tag         = r_pc[31:IDX_W+2];
    w_hit         = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    w_pred        = w_hit && r_bht[w_idx][1];
    w_u_idx       = w_u_pc[IDX_W+1:2];
    w_u_tag       = w_u_pc[31:IDX_W+2];
    w_u_hit       = r_valid[w_u_idx] && (r_tag[w_u_idx] == w_u_tag);
  end

  // Next-PC selection: redirect beats stall, stall beats prediction.
  always_comb begin
    w_next_pc = r_pc + 32'd4;
    if (bus.redirect_i) begin
      w_next_pc = w_redirect_pc;
    end else if (bus.stall_i) begin
      w_next_pc = r_pc;
    end else if (w_pred) begin
      w_next_pc = r_target[w_idx];
    end else begin
      w_next_pc = r_pc + 32'd4;
    end
  end

  // Program counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pc <= {RESET_PC[31:2], 2'b00};
    end else begin
      r_pc <= w_next_pc;
    end
  end

  // Predictor training; lookups in the same cycle see the pre-update contents.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        r_valid[i]  <= 1'b0;
        r_bht[i]    <= 2'b01;
        r_tag[i]    <= {TAG_W{1'b0}};
        r_target[i] <= 32'h0000_0000;
      end
    end else if (bus.update_en_i) begin
      if (w_u_hit) begin
        if (bus.update_taken_i) begin
          if (r_bht[w_u_idx] != 2'b11) begin
            r_bht[w_u_idx] <= r_bht[w_u_idx] + 2'b01;
          end
          r_target[w_u_idx] <= w_u_target;
        end else if (r_bht[w_u_idx] != 2'b00) begin
          r_bht[w_u_idx] <= r_bht[w_u_idx] - 2'b01;
        end
      end else if (bus.update_taken_i) begin
        r_valid[w_u_idx]  <= 1'b1;
        r_tag[w_u_idx]    <= w_u_tag;
        r_target[w_u_idx] <= w_u_target;
        r_bht[w_u_idx]    <= 2'b10;
      end
    end
  end
endmodule
